decoder_3x8_seq: RTL and testbench
==================================

DECODER_3X8_SEQ -- requirements
Module: decoder_3x8_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of cycles each decoded one-hot word is driven on out; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1: number of all-zero cycles inserted after each pulse; legal range 0..255.
REQ-003 Parameter FIFO_DEPTH, default 4: input code buffer depth; must be a power of 2 and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_code, input, 3 bits: binary code to be decoded.
REQ-007 Port in_valid, input, 1 bit: in_code is valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts in_code this cycle.
REQ-009 Port en, input, 1 bit: permits the start of a new pulse.
REQ-010 Port out, output, 8 bits: registered one-hot decode; out[k]=1 only when the code being driven equals k.
REQ-011 Port busy, output, 1 bit: high while in state DRIVE or GAP.
REQ-012 Port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: number of buffered codes.

Function
REQ-013 A code is accepted on a rising edge only when in_valid and in_ready are both 1; in_ready = (fifo_count != FIFO_DEPTH), with no dependence on in_valid.
REQ-014 FIFO ordering: pulses are emitted in acceptance order; no code is dropped or duplicated.
REQ-015 FSM states: IDLE, DRIVE, GAP.
REQ-016 IDLE -> DRIVE on an edge where the FIFO is non-empty and en=1; that edge pops the head and loads out with its one-hot value.
REQ-017 DRIVE: out holds its value for exactly HOLD_CYCLES cycles; then out goes to 0 and the FSM enters GAP, or, if GAP_CYCLES=0, takes the IDLE decision on that same edge.
REQ-018 GAP: out=0 for exactly GAP_CYCLES cycles; the last GAP edge applies the IDLE decision directly (pop into DRIVE if non-empty and en=1, else go to IDLE).
REQ-019 Latency: a code accepted at edge E into an empty FIFO with the FSM in IDLE and en=1 appears on out from edge E+1; a pop and the push of the same code never share an edge.
REQ-020 Push and pop on the same edge: fifo_count is unchanged; the push is permitted whenever the FIFO was not full before that edge.
REQ-021 en=0 blocks only the start of a new pulse; a pulse in DRIVE or GAP always completes.
REQ-022 Internal counters and pointers wrap modulo their width; no out-of-range values.
REQ-023 out is never non-zero with more than one bit set.

Reset
REQ-024 With rst=1 at an edge: FSM=IDLE, out=0, busy=0, FIFO emptied (fifo_count=0, in_ready=1), hold and gap counters=0.
REQ-025 Reset asserted mid-pulse aborts the pulse at that edge and discards all buffered codes; the input is not accepted on that edge.

Structure
REQ-026 Shared package decoder_pkg: FSM state encoding constants, the one-hot decode function, and the default parameter values.
REQ-027 One sub-module, sync_fifo (parameters WIDTH=3, DEPTH), holds the code buffer; the FSM, counters and output register live in decoder_3x8_seq.

Verification (HOLD_CYCLES=4, GAP_CYCLES=1, FIFO_DEPTH=4 unless stated)
REQ-028 Single code: push 3'd5 at edge E with en=1 -> out=8'h20 for edges E+1..E+4, 0 from E+5, busy 0 from E+6.
REQ-029 Back-to-back: push 5 then 2 on consecutive edges -> 8'h20 for four cycles, one cycle of 0, then 8'h04 for four cycles.
REQ-030 Full FIFO: en=0, push codes 0,1,2,3 -> fifo_count=4, in_ready=0, a fifth in_valid is ignored; set en=1 -> pulses 01,02,04,08 in order.
REQ-031 en dropped mid-DRIVE on code 7 -> 8'h80 completes all 4 cycles; the next buffered code waits until en=1.
REQ-032 rst=1 during the second DRIVE cycle with 2 codes queued -> out=0, fifo_count=0 the next cycle, and no further pulses.
REQ-033 GAP_CYCLES=0, HOLD_CYCLES=1, codes 6,6 -> out=8'h40 on two consecutive cycles, no zero cycle between them.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared definitions for the sequenced 3-to-8 decoder: FSM
//                state encoding, default parameter values and the one-hot
//                decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  // Default parameter values for decoder_3x8_seq
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 1;
  localparam int DEF_FIFO_DEPTH  = 4;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Binary code to one-hot word: bit k set for code k
  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'd1 << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_3x8_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_3x8_seq_if
//  Description : Bus between a code producer (master) and decoder_3x8_seq
//                (slave).
//                  in_code    [2:0]  code to decode          (master -> slave)
//                  in_valid          in_code valid           (master -> slave)
//                  en                permit new pulse start  (master -> slave)
//                  in_ready          code accepted this cycle(slave -> master)
//                  out        [7:0]  registered one-hot word (slave -> master)
//                  busy              pulse in progress       (slave -> master)
//                  fifo_count        buffered code count     (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface decoder_3x8_seq_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    in_code;
  logic          in_valid;
  logic          in_ready;
  logic          en;
  logic [7:0]    out;
  logic          busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output in_code, in_valid, en,
    input  in_ready, out, busy, fifo_count
  );

  modport slave (
    input  in_code, in_valid, en,
    output in_ready, out, busy, fifo_count
  );

endinterface
`default_nettype wire

// File: rtl/decoder_3x8_seq_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. dout_o presents the head entry
//                whenever the FIFO is non-empty.
//                  clk, rst         clock, synchronous active-high reset
//                  push_i / din_i   write request and data (ignored if full)
//                  pop_i            read request (ignored if empty)
//                  dout_o           head entry
//                  count_o          number of stored entries
//                  full_o, empty_o  status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   C_CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == C_CNT_FULL);
  assign empty_o   = (count_q == '0);
  // A push is judged against the state before the edge, so a simultaneous
  // pop does not make room for it when full.
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign dout_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + C_CNT_ONE;
        2'b01:   count_q <= count_q - C_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder_3x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_3x8_seq
//  Description : Buffered 3-to-8 decoder that emits each accepted code as a
//                one-hot pulse of HOLD_CYCLES cycles followed by GAP_CYCLES
//                all-zero cycles, in acceptance order.
//                  clk, rst  clock, synchronous active-high reset
//                  bus       decoder_3x8_seq_if.slave (code input, en,
//                            in_ready, out, busy, fifo_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_3x8_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  decoder_3x8_seq_if.slave bus
);
  localparam int         CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] C_GAP_LAST  = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    out_q, out_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    gap_q, gap_d;

  logic [2:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_can_start;
  logic          w_decide;

  assign w_push = bus.in_valid && !w_full;

  sync_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .din_i   (bus.in_code),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_can_start = !w_empty && bus.en;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    w_pop    = 1'b0;
    w_decide = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        w_decide = 1'b1;
      end
      ST_DRIVE: begin
        if (hold_q == C_HOLD_LAST) begin
          out_d  = '0;
          hold_d = '0;
          if (GAP_CYCLES == 0) begin
            // No gap: the next pulse may start on this very edge.
            w_decide = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == C_GAP_LAST) begin
          w_decide = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
    endcase

    // Shared start-or-idle decision taken from IDLE, the last DRIVE edge
    // (zero gap) and the last GAP edge.
    if (w_decide) begin
      hold_d = '0;
      gap_d  = '0;
      if (w_can_start) begin
        w_pop   = 1'b1;
        state_d = ST_DRIVE;
        out_d   = onehot8(w_head);
      end else begin
        state_d = ST_IDLE;
        out_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.busy       = (state_q == ST_DRIVE) || (state_q == ST_GAP);
  assign bus.in_ready   = !w_full;
  assign bus.fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_3x8_seq
//  Description : Scoreboard bench for decoder_3x8_seq. dut1 uses HOLD=4,
//                GAP=1, DEPTH=4; dut2 uses HOLD=1, GAP=0, DEPTH=4. Stimulus
//                queues the hand-computed one-hot word of every accepted
//                code; monitors pop and compare as pulses appear on out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3x8_seq;
  localparam int HOLD1 = 4;
  localparam int GAP1  = 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  decoder_3x8_seq_if #(.FIFO_DEPTH(4)) b1();
  decoder_3x8_seq_if #(.FIFO_DEPTH(4)) b2();

  decoder_3x8_seq #(.HOLD_CYCLES(HOLD1), .GAP_CYCLES(GAP1), .FIFO_DEPTH(4))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  decoder_3x8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(4))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [2:0] code, input logic [7:0] exp);
    b1.in_code  = code;
    b1.in_valid = 1'b1;
    q1.push_back(exp);
    tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic push2(input logic [2:0] code, input logic [7:0] exp);
    b2.in_code  = code;
    b2.in_valid = 1'b1;
    q2.push_back(exp);
    tick();
    b2.in_valid = 1'b0;
  endtask

  // Monitor for dut1: segments out into HOLD1-long runs, checks gap length
  // and one-hot shape, and compares each completed pulse with the queue.
  int         run1  = 0;
  int         zrun1 = 0;
  bit         seen1 = 1'b0;
  logic [7:0] cur1  = '0;
  logic [7:0] exp1;

  always @(negedge clk) begin
    if (rst) begin
      run1  = 0;
      zrun1 = 0;
      seen1 = 1'b0;
    end else if (b1.out == 8'h00) begin
      if (run1 != 0) begin
        checks++; errors++;
        $display("FAIL pulse_len got %0d cycles expected %0d", run1, HOLD1);
        run1 = 0;
      end
      zrun1++;
    end else begin
      if (!$onehot(b1.out)) begin
        checks++; errors++;
        $display("FAIL onehot got %0h expected single bit", b1.out);
      end
      if (run1 == 0) begin
        if (seen1) begin
          checks++;
          if (zrun1 < GAP1) begin
            errors++;
            $display("FAIL gap_len got %0d expected >= %0d", zrun1, GAP1);
          end
        end
        cur1 = b1.out;
        run1 = 1;
      end else if (b1.out != cur1) begin
        checks++; errors++;
        $display("FAIL pulse_change got %0h expected %0h", b1.out, cur1);
        cur1 = b1.out;
        run1 = 1;
      end else begin
        run1++;
      end
      if (run1 == HOLD1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected got %0h expected no pulse", cur1);
        end else begin
          exp1 = q1.pop_front();
          if (exp1 != cur1) begin
            errors++;
            $display("FAIL sb1_pulse got %0h expected %0h", cur1, exp1);
          end
        end
        run1  = 0;
        seen1 = 1'b1;
        zrun1 = 0;
      end
    end
  end

  // Monitor for dut2: HOLD=1, so each non-zero cycle is one pulse.
  logic [7:0] exp2;
  always @(negedge clk) begin
    if (!rst && b2.out != 8'h00) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb2_unexpected got %0h expected no pulse", b2.out);
      end else begin
        exp2 = q2.pop_front();
        if (exp2 != b2.out) begin
          errors++;
          $display("FAIL sb2_pulse got %0h expected %0h", b2.out, exp2);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    b1.in_code = '0; b1.in_valid = 1'b0; b1.en = 1'b0;
    b2.in_code = '0; b2.in_valid = 1'b0; b2.en = 1'b0;
    repeat (2) tick();
    chk("rst_out",      32'(b1.out), 32'h00);
    chk("rst_busy",     32'(b1.busy), 32'd0);
    chk("rst_count",    32'(b1.fifo_count), 32'd0);
    chk("rst_in_ready", 32'(b1.in_ready), 32'd1);
    chk("rst_out2",     32'(b2.out), 32'h00);
    rst = 1'b0;
    tick();

    // Single code 5: latency one edge, four cycles of 8'h20, one gap cycle.
    b1.en = 1'b1;
    push1(3'd5, 8'h20);
    chk("single_e0_out",   32'(b1.out), 32'h00);
    chk("single_e0_count", 32'(b1.fifo_count), 32'd1);
    tick();
    chk("single_e1_out",   32'(b1.out), 32'h20);
    chk("single_e1_busy",  32'(b1.busy), 32'd1);
    chk("single_e1_count", 32'(b1.fifo_count), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("single_hold_out", 32'(b1.out), 32'h20);
    end
    tick();
    chk("single_e5_out",  32'(b1.out), 32'h00);
    chk("single_e5_busy", 32'(b1.busy), 32'd1);
    tick();
    chk("single_e6_busy", 32'(b1.busy), 32'd0);
    repeat (2) tick();

    // Back-to-back 5 then 2.
    push1(3'd5, 8'h20);
    push1(3'd2, 8'h04);
    chk("b2b_e1_out", 32'(b1.out), 32'h20);
    repeat (4) tick();
    chk("b2b_gap_out", 32'(b1.out), 32'h00);
    tick();
    chk("b2b_second_out", 32'(b1.out), 32'h04);
    repeat (6) tick();

    // Full FIFO with en=0, fifth push ignored, then drain in order.
    b1.en = 1'b0;
    push1(3'd0, 8'h01);
    push1(3'd1, 8'h02);
    push1(3'd2, 8'h04);
    push1(3'd3, 8'h08);
    chk("full_count",    32'(b1.fifo_count), 32'd4);
    chk("full_in_ready", 32'(b1.in_ready), 32'd0);
    b1.in_code = 3'd7; b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    chk("full_fifth_ignored", 32'(b1.fifo_count), 32'd4);
    chk("full_en0_out",       32'(b1.out), 32'h00);
    b1.en = 1'b1;
    tick();
    chk("drain_first_out",   32'(b1.out), 32'h01);
    chk("drain_first_count", 32'(b1.fifo_count), 32'd3);
    repeat (22) tick();
    chk("drain_count", 32'(b1.fifo_count), 32'd0);

    // Push and pop on the same edge keep the count unchanged.
    b1.en = 1'b0;
    push1(3'd3, 8'h08);
    chk("pp_pre_count", 32'(b1.fifo_count), 32'd1);
    b1.en = 1'b1;
    b1.in_code = 3'd4; b1.in_valid = 1'b1; q1.push_back(8'h10);
    tick();
    b1.in_valid = 1'b0;
    chk("pp_count", 32'(b1.fifo_count), 32'd1);
    chk("pp_out",   32'(b1.out), 32'h08);
    repeat (12) tick();

    // en dropped mid-DRIVE on code 7; next code waits for en.
    push1(3'd7, 8'h80);
    push1(3'd1, 8'h02);
    chk("en_drop_e1_out", 32'(b1.out), 32'h80);
    b1.en = 1'b0;
    repeat (3) tick();
    chk("en_drop_e4_out", 32'(b1.out), 32'h80);
    tick();
    chk("en_drop_e5_out", 32'(b1.out), 32'h00);
    tick();
    chk("en_drop_e6_busy", 32'(b1.busy), 32'd0);
    repeat (3) tick();
    chk("en_wait_out",   32'(b1.out), 32'h00);
    chk("en_wait_count", 32'(b1.fifo_count), 32'd1);
    b1.en = 1'b1;
    tick();
    chk("en_resume_out", 32'(b1.out), 32'h02);
    repeat (6) tick();

    // Reset in the second DRIVE cycle with two codes queued.
    push1(3'd5, 8'h20);
    push1(3'd6, 8'h40);
    push1(3'd7, 8'h80);
    chk("rstmid_pre_out",   32'(b1.out), 32'h20);
    chk("rstmid_pre_count", 32'(b1.fifo_count), 32'd2);
    rst = 1'b1;
    b1.in_code = 3'd3; b1.in_valid = 1'b1;
    q1.delete();
    q2.delete();
    tick();
    rst = 1'b0;
    b1.in_valid = 1'b0;
    chk("rstmid_out",      32'(b1.out), 32'h00);
    chk("rstmid_count",    32'(b1.fifo_count), 32'd0);
    chk("rstmid_busy",     32'(b1.busy), 32'd0);
    chk("rstmid_in_ready", 32'(b1.in_ready), 32'd1);
    repeat (12) tick();
    chk("rstmid_after_out",   32'(b1.out), 32'h00);
    chk("rstmid_after_count", 32'(b1.fifo_count), 32'd0);

    // dut2: HOLD=1, GAP=0, codes 6,6 give two adjacent 8'h40 cycles.
    push2(3'd6, 8'h40);
    push2(3'd6, 8'h40);
    chk("z_count", 32'(b2.fifo_count), 32'd2);
    b2.en = 1'b1;
    tick();
    chk("z_first_out", 32'(b2.out), 32'h40);
    tick();
    chk("z_second_out",  32'(b2.out), 32'h40);
    chk("z_second_busy", 32'(b2.busy), 32'd1);
    tick();
    chk("z_end_out", 32'(b2.out), 32'h00);
    repeat (3) tick();

    chk("sb1_empty", 32'(q1.size()), 32'd0);
    chk("sb2_empty", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
